// File: rtl/lcd_write_cycle_gen.sv
// lcd_write_cycle_gen
// Produces one complete HD44780-style bus write per accepted request:
// RS/data setup, E pulse, hold, an optional inter-nibble gap (4-bit bus)
// and an optional post-write execution wait, then a one-cycle oDone.
//
// Optional feature: define LCD_WRITE_QUEUE_EN to add a one-entry pending
// request register so the sequencer can post the next write while the
// current one is still on the bus.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a request; RS/data keep their last driven values
// SETUP  | E=0, RS and current byte/nibble driven before the E rise
// ENABLE | E=1, data stable
// HOLD   | E=0, data held after the E fall
// GAP    | E=0, spacing between high and low nibble (4-bit bus only)
// WAIT   | E=0, LCD executes the command; bus keeps its last value
// DONE   | single cycle with oDone=1
module lcd_write_cycle_gen #(
    parameter int MODE_4BIT    = 0,
    parameter int T_SETUP      = 2,
    parameter int T_ENABLE     = 12,
    parameter int T_HOLD       = 1,
    parameter int T_NIBBLE_GAP = 50,
    parameter int T_POST       = 2000,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                                  Clock,
    input  logic                                  Reset,
    input  logic                                  iStart,
    input  logic                                  iRS,
    input  logic [7:0]                            iData,
    output logic                                  oReady,
    output logic                                  oBusy,
    output logic                                  oDone,
    output logic                                  oLCD_Enabled,
    output logic                                  oLCD_RS,
    output logic                                  oLCD_RW,
    output logic [((MODE_4BIT != 0) ? 4 : 8)-1:0] oLCD_Data
);

    localparam int DW = (MODE_4BIT != 0) ? 4 : 8;

    // Terminal timer values; the timer restarts at 0 on every state entry.
    // Zero-length optional states are skipped, so their terminal value is
    // only meaningful when the parameter is non-zero.
    localparam logic [CNT_WIDTH-1:0] TC_SETUP  = CNT_WIDTH'(T_SETUP - 1);
    localparam logic [CNT_WIDTH-1:0] TC_ENABLE = CNT_WIDTH'(T_ENABLE - 1);
    localparam logic [CNT_WIDTH-1:0] TC_HOLD   = CNT_WIDTH'(T_HOLD - 1);
    localparam logic [CNT_WIDTH-1:0] TC_GAP    =
        CNT_WIDTH'((T_NIBBLE_GAP > 0) ? T_NIBBLE_GAP - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] TC_POST   =
        CNT_WIDTH'((T_POST > 0) ? T_POST - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ENABLE = 3'd2,
        S_HOLD   = 3'd3,
        S_GAP    = 3'd4,
        S_WAIT   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_timer;
    logic                   r_nibble_lo;
    logic [3:0]             r_low_nib;
    logic                   r_lcd_e;
    logic                   r_lcd_rs;
    logic [DW-1:0]          r_lcd_data;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_launch_idle;
    logic                   w_launch_done;
    logic                   w_launch_rs;
    logic [7:0]             w_launch_data;
    logic [DW-1:0]          w_launch_word;
    logic [DW-1:0]          w_low_word;
    logic                   w_tc;

    assign w_accept = iStart & w_ready;

`ifdef LCD_WRITE_QUEUE_EN
    logic                   r_pend_valid;
    logic                   r_pend_rs;
    logic [7:0]             r_pend_data;

    assign w_ready       = ~r_pend_valid;
    // A waiting pending entry always has priority over the request pins.
    assign w_launch_rs   = r_pend_valid ? r_pend_rs   : iRS;
    assign w_launch_data = r_pend_valid ? r_pend_data : iData;
    assign w_launch_idle = r_pend_valid | w_accept;
    assign w_launch_done = r_pend_valid;

    // Pending entry: captured while a write is in flight, released when launched.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_pend_valid <= 1'b0;
            r_pend_rs    <= 1'b0;
            r_pend_data  <= 8'h00;
        end else if (r_pend_valid) begin
            if ((r_state == S_IDLE) || (r_state == S_DONE)) begin
                r_pend_valid <= 1'b0;
            end
        end else if (w_accept && (r_state != S_IDLE)) begin
            r_pend_valid <= 1'b1;
            r_pend_rs    <= iRS;
            r_pend_data  <= iData;
        end
    end
`else
    assign w_ready       = (r_state == S_IDLE);
    assign w_launch_rs   = iRS;
    assign w_launch_data = iData;
    assign w_launch_idle = w_accept;
    assign w_launch_done = 1'b0;
`endif

    // Select what goes on the bus first and what goes second (4-bit only).
    if (MODE_4BIT != 0) begin : g_bus4
        assign w_launch_word = w_launch_data[7:4];
        assign w_low_word    = r_low_nib;
    end else begin : g_bus8
        assign w_launch_word = w_launch_data;
        assign w_low_word    = {4'h0, r_low_nib};
    end

    // Terminal-count decode for the timed states.
    always_comb begin
        w_tc = 1'b0;
        case (r_state)
            S_SETUP:  w_tc = (r_timer == TC_SETUP);
            S_ENABLE: w_tc = (r_timer == TC_ENABLE);
            S_HOLD:   w_tc = (r_timer == TC_HOLD);
            S_GAP:    w_tc = (r_timer == TC_GAP);
            S_WAIT:   w_tc = (r_timer == TC_POST);
            default:  w_tc = 1'b0;
        endcase
    end

    // Write-cycle sequencer with registered pin outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_nibble_lo <= 1'b0;
            r_low_nib   <= 4'h0;
            r_lcd_e     <= 1'b0;
            r_lcd_rs    <= 1'b0;
            r_lcd_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (w_launch_idle) begin
                        r_state     <= S_SETUP;
                        r_busy      <= 1'b1;
                        r_lcd_rs    <= w_launch_rs;
                        r_lcd_data  <= w_launch_word;
                        r_low_nib   <= w_launch_data[3:0];
                        r_nibble_lo <= 1'b0;
                    end
                end

                S_SETUP: begin
                    if (w_tc) begin
                        r_state <= S_ENABLE;
                        r_timer <= '0;
                        r_lcd_e <= 1'b1;
                    end else begin
                        r_timer <= r_timer + CNT_WIDTH'(1);
                    end
                end

                S_ENABLE: begin
                    if (w_tc) begin
                        r_state <= S_HOLD;
                        r_timer <= '0;
                        r_lcd_e <= 1'b0;
                    end else begin
                        r_timer <= r_timer + CNT_WIDTH'(1);
                    end
                end

                S_HOLD: begin
                    if (w_tc) begin
                        r_timer <= '0;
                        if ((MODE_4BIT != 0) && !r_nibble_lo) begin
                            if (T_NIBBLE_GAP == 0) begin
                                r_state     <= S_SETUP;
                                r_lcd_data  <= w_low_word;
                                r_nibble_lo <= 1'b1;
                            end else begin
                                r_state <= S_GAP;
                            end
                        end else if (T_POST == 0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_timer <= r_timer + CNT_WIDTH'(1);
                    end
                end

                S_GAP: begin
                    if (w_tc) begin
                        r_state     <= S_SETUP;
                        r_timer     <= '0;
                        r_lcd_data  <= w_low_word;
                        r_nibble_lo <= 1'b1;
                    end else begin
                        r_timer <= r_timer + CNT_WIDTH'(1);
                    end
                end

                S_WAIT: begin
                    if (w_tc) begin
                        r_state <= S_DONE;
                        r_timer <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_timer <= r_timer + CNT_WIDTH'(1);
                    end
                end

                S_DONE: begin
                    r_timer <= '0;
                    if (w_launch_done) begin
                        // Chain straight into the pending write; stay busy.
                        r_state     <= S_SETUP;
                        r_lcd_rs    <= w_launch_rs;
                        r_lcd_data  <= w_launch_word;
                        r_low_nib   <= w_launch_data[3:0];
                        r_nibble_lo <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                    r_lcd_e <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign oReady       = w_ready;
    assign oBusy        = r_busy;
    assign oDone        = r_done;
    assign oLCD_Enabled = r_lcd_e;
    assign oLCD_RS      = r_lcd_rs;
    assign oLCD_RW      = 1'b0;
    assign oLCD_Data    = r_lcd_data;

endmodule

// File: tb/tb_lcd_write_cycle_gen.sv
// Bench for lcd_write_cycle_gen: an 8-bit instance (T_POST=10) and a 4-bit
// instance (T_POST=0). Expected pin values come from a cycle-offset model
// derived from the write timing rules.
`timescale 1ns/1ps
module tb_lcd_write_cycle_gen;

    localparam int S     = 2;
    localparam int EN    = 12;
    localparam int H     = 1;
    localparam int G     = 50;
    localparam int POST8 = 10;
    localparam int POST4 = 0;
    localparam int L8    = S + EN + H + POST8 + 1;
    localparam int L4    = (S + EN + H + G) + S + EN + H + POST4 + 1;

    logic Clock = 1'b0;
    logic Reset = 1'b0;

    logic       s8 = 1'b0, rs8 = 1'b0;
    logic [7:0] d8 = 8'h00;
    logic       rdy8, busy8, done8, e8, lrs8, rw8;
    logic [7:0] ld8;

    logic       s4 = 1'b0, rs4 = 1'b0;
    logic [7:0] d4 = 8'h00;
    logic       rdy4, busy4, done4, e4, lrs4, rw4;
    logic [3:0] ld4;

    int n_tests = 0;
    int n_fail  = 0;

    int low_run  = 0;
    int last_low = -1;
    bit seen_hi  = 1'b0;

    always #5 Clock = ~Clock;

    lcd_write_cycle_gen #(
        .MODE_4BIT(0), .T_SETUP(S), .T_ENABLE(EN), .T_HOLD(H),
        .T_NIBBLE_GAP(G), .T_POST(POST8), .CNT_WIDTH(16)
    ) dut8 (
        .Clock(Clock), .Reset(Reset), .iStart(s8), .iRS(rs8), .iData(d8),
        .oReady(rdy8), .oBusy(busy8), .oDone(done8), .oLCD_Enabled(e8),
        .oLCD_RS(lrs8), .oLCD_RW(rw8), .oLCD_Data(ld8)
    );

    lcd_write_cycle_gen #(
        .MODE_4BIT(1), .T_SETUP(S), .T_ENABLE(EN), .T_HOLD(H),
        .T_NIBBLE_GAP(G), .T_POST(POST4), .CNT_WIDTH(16)
    ) dut4 (
        .Clock(Clock), .Reset(Reset), .iStart(s4), .iRS(rs4), .iData(d4),
        .oReady(rdy4), .oBusy(busy4), .oDone(done4), .oLCD_Enabled(e4),
        .oLCD_RS(lrs4), .oLCD_RW(rw4), .oLCD_Data(ld4)
    );

    task automatic chk(input string name, input int n, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s n=%0d: got %0h, expected %0h", name, n, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic st, input logic r,
                         input logic [7:0] d);
        if (which == 0) begin
            s8 = st; rs8 = r; d8 = d;
        end else begin
            s4 = st; rs4 = r; d4 = d;
        end
    endtask

    task automatic sample(input int which, output logic e, output logic b,
                          output logic dn, output logic rd, output logic r,
                          output logic w, output logic [7:0] dat);
        if (which == 0) begin
            e = e8; b = busy8; dn = done8; rd = rdy8; r = lrs8; w = rw8; dat = ld8;
        end else begin
            e = e4; b = busy4; dn = done4; rd = rdy4; r = lrs4; w = rw4;
            dat = {4'h0, ld4};
        end
    endtask

    // Expected pins n cycles after the accepting edge.
    function automatic void model(input int which, input int n, input logic [7:0] d,
                                  output logic e, output logic b, output logic dn,
                                  output logic rd, output logic [7:0] dat);
        int p, l, n2, post;
        bit m4;
        m4   = (which == 1);
        post = m4 ? POST4 : POST8;
        p    = m4 ? (S + EN + H + G) : 0;
        l    = p + S + EN + H + post + 1;
        n2   = (n > p) ? n - p : n;
        e    = (n <= l) && (n2 >= S + 1) && (n2 <= S + EN);
        b    = (n >= 1) && (n <= l);
        dn   = (n == l);
        rd   = (n > l);
        if (m4) dat = (n > p) ? {4'h0, d[3:0]} : {4'h0, d[7:4]};
        else    dat = d;
    endfunction

    // Issue one request in the current (idle) cycle and check nmax cycles.
    task automatic run_write(input int which, input logic r, input logic [7:0] d,
                             input int noise_at, input logic [7:0] noise_d,
                             input int nmax, output int dones, output int done_at,
                             output logic [7:0] data1, output logic [7:0] data_last);
        logic e, b, dn, rd, orr, ow;
        logic [7:0] od;
        logic xe, xb, xd, xr;
        logic [7:0] xdat;
        dones = 0; done_at = -1; data1 = 8'hxx; data_last = 8'hxx;
        sample(which, e, b, dn, rd, orr, ow, od);
        chk("ready_before_req", 0, rd, 1'b1);
        drive(which, 1'b1, r, d);
        @(posedge Clock);
        #1;
        drive(which, 1'b0, logic'($urandom_range(0, 1)), 8'($urandom));
        for (int n = 1; n <= nmax; n++) begin
            @(negedge Clock);
            sample(which, e, b, dn, rd, orr, ow, od);
            model(which, n, d, xe, xb, xd, xr, xdat);
            chk("lcd_e", n, e, xe);
            chk("busy", n, b, xb);
            chk("done", n, dn, xd);
            chk("ready", n, rd, xr);
            chk("lcd_rs", n, orr, r);
            chk("lcd_rw", n, ow, 1'b0);
            chk("lcd_data", n, od, xdat);
            if (dn) begin
                dones++;
                if (done_at < 0) done_at = n;
            end
            if (n == 1) data1 = od;
            data_last = od;
            if (e) begin
                if (seen_hi && low_run > 0) last_low = low_run;
                seen_hi = 1'b1;
                low_run = 0;
            end else begin
                low_run++;
            end
            if (n == noise_at) drive(which, 1'b1, ~r, noise_d);
            else if (n == noise_at + 1) drive(which, 1'b0, r, d);
        end
    endtask

    typedef struct {
        int         which;
        logic       rs;
        logic [7:0] data;
        int         noise_at;
        logic [7:0] noise_d;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
        int         exp_done_at;
        int         exp_dones;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int dones, done_at, lim;
        logic [7:0] dat1, datl;

        tbl[0] = '{0, 1'b0, 8'h38, -5, 8'h00, 8'h38, 8'h38, 26, 1};
        tbl[1] = '{1, 1'b1, 8'h28, -5, 8'h00, 8'h02, 8'h08, 81, 1};
        tbl[2] = '{0, 1'b0, 8'h38,  5, 8'h01, 8'h38, 8'h38, 26, 1};
        tbl[3] = '{0, 1'b1, 8'hA5, -5, 8'h00, 8'hA5, 8'hA5, 26, 1};
        tbl[4] = '{1, 1'b0, 8'hC3, 30, 8'h55, 8'h0C, 8'h03, 81, 1};

        #1 Reset = 1'b1;
        #2;
        chk("rst_e8", 0, e8, 1'b0);
        chk("rst_busy8", 0, busy8, 1'b0);
        chk("rst_data8", 0, ld8, 8'h00);
        chk("rst_e4", 0, e4, 1'b0);
        chk("rst_data4", 0, ld4, 4'h0);
        chk("rst_done4", 0, done4, 1'b0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        chk("ready8_after_rst", 0, rdy8, 1'b1);
        chk("ready4_after_rst", 0, rdy4, 1'b1);

        // Reset in the middle of the E pulse.
        run_write(0, 1'b1, 8'h38, -5, 8'h00, 8, dones, done_at, dat1, datl);
        chk("e_high_cycle8", 8, e8, 1'b1);
        #1 Reset = 1'b1;
        #1;
        chk("async_e_drop", 8, e8, 1'b0);
        chk("async_busy_drop", 8, busy8, 1'b0);
        chk("async_rs_drop", 8, lrs8, 1'b0);
        chk("async_data_drop", 8, ld8, 8'h00);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (done8) dones++;
            if (i == 0) chk("ready_after_abort", i, rdy8, 1'b1);
        end
        chk("no_done_after_abort", 0, dones, 0);

        // Directed table.
        for (int i = 0; i < 5; i++) begin
            lim = (tbl[i].which == 0) ? L8 : L4;
            run_write(tbl[i].which, tbl[i].rs, tbl[i].data, tbl[i].noise_at,
                      tbl[i].noise_d, lim + 4, dones, done_at, dat1, datl);
            chk("tbl_first_word", i, dat1, tbl[i].exp_first);
            chk("tbl_last_word", i, datl, tbl[i].exp_last);
            chk("tbl_done_at", i, done_at, tbl[i].exp_done_at);
            chk("tbl_done_count", i, dones, tbl[i].exp_dones);
            @(negedge Clock);
        end

        // Back-to-back: new request in the idle cycle right after oDone.
        seen_hi = 1'b0; low_run = 0; last_low = -1;
        run_write(0, 1'b0, 8'h0F, -5, 8'h00, L8 + 1, dones, done_at, dat1, datl);
        run_write(0, 1'b1, 8'h06, -5, 8'h00, L8 + 1, dones, done_at, dat1, datl);
        chk("b2b_low_min", 0, (last_low >= H + POST8 + 1 + S), 1'b1);
        chk("b2b_low_exact", 0, last_low, (L8 + 1 - (S + EN)) + S);

        // Randomized writes with random gaps and ignored mid-write requests.
        for (int i = 0; i < 16; i++) begin
            int w, na;
            w  = int'($urandom_range(0, 1));
            na = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : -5;
            repeat ($urandom_range(0, 2)) @(negedge Clock);
            lim = (w == 0) ? L8 : L4;
            run_write(w, logic'($urandom_range(0, 1)), 8'($urandom), na, 8'($urandom),
                      lim + 1, dones, done_at, dat1, datl);
            chk("rand_done_count", i, dones, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
